// File: rtl/img_pixel_engine_if.sv
// Frame BRAM port bundle for the pixel engine: read data in, write data/enable
// and both addresses out. The engine is the master; the BRAM is the slave.
interface img_pixel_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17
);
  logic [DATA_W-1:0] r_in;
  logic [DATA_W-1:0] g_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] r_out;
  logic [DATA_W-1:0] g_out;
  logic [DATA_W-1:0] b_out;
  logic              we;
  logic [ADDR_W-1:0] addr_read;
  logic [ADDR_W-1:0] addr_write;

  modport master (
    input  r_in, g_in, b_in,
    output r_out, g_out, b_out, we, addr_read, addr_write
  );

  modport slave (
    output r_in, g_in, b_in,
    input  r_out, g_out, b_out, we, addr_read, addr_write
  );
endinterface

// File: rtl/img_pixel_engine.sv
// Multi-pass in-place pixel engine: gray-world compensation, RGB->YCbCr and
// Cb/Cr skin segmentation over one frame held in BRAM, with a skin-pixel count.
module img_pixel_engine #(
  parameter int DATA_W  = 8,
  parameter int NUM_PIX = 76800,
  parameter int ADDR_W  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            mode,
  input  logic [DATA_W-1:0]     cb_lo,
  input  logic [DATA_W-1:0]     cb_hi,
  input  logic [DATA_W-1:0]     cr_lo,
  input  logic [DATA_W-1:0]     cr_hi,
  img_pixel_engine_if.master    bram,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     skin_count
);

  localparam int ACC_W  = DATA_W + $clog2(NUM_PIX);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int MAX_V  = (1 << DATA_W) - 1;
  localparam int S      = DATA_W - 8;
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(NUM_PIX - 1);
  localparam logic [CNT_W-1:0] ACC_END  = CNT_W'(NUM_PIX);
  localparam logic [CNT_W-1:0] PASS_END = CNT_W'(NUM_PIX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_MEAN, S_COMP, S_YCC, S_SEG, S_FIN
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:1]          mode_q;
  logic [DATA_W-1:0]   cb_lo_q, cb_hi_q, cr_lo_q, cr_hi_q;
  logic [ACC_W-1:0]    acc_r, acc_g, acc_b;
  logic [DATA_W-1:0]   mean_r, mean_g, mean_b, max_mean;
  logic [DATA_W-1:0]   px_r, px_g, px_b;
  logic                px_mask;
  int                  ri, gi, bi;

  // First enabled pass among the bits still set in m; nothing left means FIN.
  function automatic state_t pick(input logic [2:0] m);
    if (m[0]) return S_ACCUM;
    if (m[1]) return S_YCC;
    if (m[2]) return S_SEG;
    return S_FIN;
  endfunction

  function automatic logic [DATA_W-1:0] div_mean(input logic [ACC_W-1:0] s);
    return DATA_W'(s / ACC_W'(NUM_PIX));
  endfunction

  function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a, b, c);
    logic [DATA_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // mean <= max_mean, so the quotient always fits back into DATA_W bits.
  function automatic logic [DATA_W-1:0] comp_ch(input logic [DATA_W-1:0] x, m, mx);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(x) * PROD_W'(m);
    if (mx == '0) return x;
    return DATA_W'(prod / PROD_W'(mx));
  endfunction

  function automatic logic [DATA_W-1:0] clamp(input int v);
    if (v < 0) return '0;
    if (v > MAX_V) return '1;
    return DATA_W'(v);
  endfunction

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves a value held, which would infer a latch.
  always_comb begin
    ri      = int'(bram.r_in);
    gi      = int'(bram.g_in);
    bi      = int'(bram.b_in);
    px_r    = bram.r_in;
    px_g    = bram.g_in;
    px_b    = bram.b_in;
    px_mask = 1'b0;
    case (state)
      S_COMP: begin
        px_r = comp_ch(bram.r_in, mean_r, max_mean);
        px_g = comp_ch(bram.g_in, mean_g, max_mean);
        px_b = comp_ch(bram.b_in, mean_b, max_mean);
      end
      S_YCC: begin
        px_r = clamp((16 << S)  + ((66 * ri + 129 * gi + 25 * bi + 128) >>> 8));
        px_g = clamp((128 << S) + ((-38 * ri - 74 * gi + 112 * bi + 128) >>> 8));
        px_b = clamp((128 << S) + ((112 * ri - 94 * gi - 18 * bi + 128) >>> 8));
      end
      S_SEG: begin
        px_mask = (bram.g_in > cb_lo_q) && (bram.g_in < cb_hi_q) &&
                  (bram.b_in > cr_lo_q) && (bram.b_in < cr_hi_q);
        px_r = px_mask ? '1 : '0;
        px_g = px_r;
        px_b = px_r;
      end
      default: ;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; the reset branch is synchronous to clk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      mode_q          <= '0;
      cb_lo_q         <= '0;
      cb_hi_q         <= '0;
      cr_lo_q         <= '0;
      cr_hi_q         <= '0;
      acc_r           <= '0;
      acc_g           <= '0;
      acc_b           <= '0;
      mean_r          <= '0;
      mean_g          <= '0;
      mean_b          <= '0;
      max_mean        <= '0;
      bram.r_out      <= '0;
      bram.g_out      <= '0;
      bram.b_out      <= '0;
      bram.we         <= 1'b0;
      bram.addr_read  <= '0;
      bram.addr_write <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      skin_count      <= '0;
    end else begin
      bram.we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (done) begin
            if (!start) done <= 1'b0;
          end else if (start) begin
            mode_q         <= mode[2:1];
            cb_lo_q        <= cb_lo;
            cb_hi_q        <= cb_hi;
            cr_lo_q        <= cr_lo;
            cr_hi_q        <= cr_hi;
            acc_r          <= '0;
            acc_g          <= '0;
            acc_b          <= '0;
            skin_count     <= '0;
            busy           <= 1'b1;
            cnt            <= '0;
            bram.addr_read <= '0;
            state          <= pick(mode);
          end
        end
        S_ACCUM: begin
          // Read data lags the address by one cycle, so sums start at cnt=1.
          if (cnt != '0) begin
            acc_r <= acc_r + ACC_W'(bram.r_in);
            acc_g <= acc_g + ACC_W'(bram.g_in);
            acc_b <= acc_b + ACC_W'(bram.b_in);
          end
          if (cnt == ACC_END) begin
            state <= S_MEAN;
          end else begin
            cnt            <= cnt + 1'b1;
            bram.addr_read <= (cnt < PIX_LAST) ? ADDR_W'(cnt + 1'b1) : '0;
          end
        end
        S_MEAN: begin
          mean_r         <= div_mean(acc_r);
          mean_g         <= div_mean(acc_g);
          mean_b         <= div_mean(acc_b);
          max_mean       <= max3(div_mean(acc_r), div_mean(acc_g), div_mean(acc_b));
          cnt            <= '0;
          bram.addr_read <= '0;
          state          <= S_COMP;
        end
        S_COMP, S_YCC, S_SEG: begin
          if (cnt != '0 && cnt <= ACC_END) begin
            bram.we         <= 1'b1;
            bram.addr_write <= ADDR_W'(cnt - 1'b1);
            bram.r_out      <= px_r;
            bram.g_out      <= px_g;
            bram.b_out      <= px_b;
            if (px_mask && skin_count != '1) skin_count <= skin_count + 1'b1;
          end
          if (cnt == PASS_END) begin
            cnt            <= '0;
            bram.addr_read <= '0;
            case (state)
              S_COMP:  state <= pick({mode_q, 1'b0});
              S_YCC:   state <= pick({mode_q[2], 2'b00});
              default: state <= S_FIN;
            endcase
          end else begin
            cnt            <= cnt + 1'b1;
            bram.addr_read <= (cnt < PIX_LAST) ? ADDR_W'(cnt + 1'b1) : '0;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_pixel_engine.sv
// Scoreboard bench for img_pixel_engine: a BRAM model feeds frames, a reference
// model pushes expected writes, and every write is popped and compared.
module tb_img_pixel_engine;
  localparam int DW = 8;
  localparam int NP = 16;
  localparam int AW = 5;

  typedef struct {
    int addr;
    int r;
    int g;
    int b;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    mode = '0;
  logic [DW-1:0] cb_lo = '0, cb_hi = '0, cr_lo = '0, cr_hi = '0;
  logic          busy, done;
  logic [AW-1:0] skin_count;

  wr_t exp_q[$];
  wr_t e_mon;
  int  mr[NP], mg[NP], mb[NP];
  int  rd_pend;
  int  n_cmp, n_err;
  int  cyc, wait_n;

  img_pixel_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bram ();

  img_pixel_engine #(.DATA_W(DW), .NUM_PIX(NP), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .cb_lo      (cb_lo),
    .cb_hi      (cb_hi),
    .cr_lo      (cr_lo),
    .cr_hi      (cr_hi),
    .bram       (bram),
    .busy       (busy),
    .done       (done),
    .skin_count (skin_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // BRAM model, evaluated mid-cycle: writes land, then read data for the
  // address presented in the previous cycle is driven.
  always @(negedge clk) begin
    if (bram.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(bram.we), 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        check("wr_addr", 32'(bram.addr_write), e_mon.addr);
        check("wr_data", {8'h0, bram.r_out, bram.g_out, bram.b_out},
              (e_mon.r << 16) | (e_mon.g << 8) | e_mon.b);
      end
      if (bram.addr_write < NP) begin
        mr[bram.addr_write] = int'(bram.r_out);
        mg[bram.addr_write] = int'(bram.g_out);
        mb[bram.addr_write] = int'(bram.b_out);
      end
    end
    bram.r_in = (rd_pend < NP) ? DW'(mr[rd_pend]) : '0;
    bram.g_in = (rd_pend < NP) ? DW'(mg[rd_pend]) : '0;
    bram.b_in = (rd_pend < NP) ? DW'(mb[rd_pend]) : '0;
    rd_pend   = int'(bram.addr_read);
  end

  function automatic int fdiv256(input int x);
    return (x >= 0) ? x / 256 : -((-x + 255) / 256);
  endfunction

  function automatic int clip(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  // Reference model over the current memory image; pushes every expected write.
  task automatic expect_run(input logic [2:0] m, input int cbl, cbh, crl, crh,
                            output int skin);
    int r[NP], g[NP], b[NP];
    int sr, sg, sb, av_r, av_g, av_b, mx, y, u, v, k;
    skin = 0;
    for (int i = 0; i < NP; i++) begin
      r[i] = mr[i]; g[i] = mg[i]; b[i] = mb[i];
    end
    if (m[0]) begin
      sr = 0; sg = 0; sb = 0;
      for (int i = 0; i < NP; i++) begin
        sr += r[i]; sg += g[i]; sb += b[i];
      end
      av_r = sr / NP; av_g = sg / NP; av_b = sb / NP;
      mx = av_r;
      if (av_g > mx) mx = av_g;
      if (av_b > mx) mx = av_b;
      for (int i = 0; i < NP; i++) begin
        if (mx != 0) begin
          r[i] = r[i] * av_r / mx;
          g[i] = g[i] * av_g / mx;
          b[i] = b[i] * av_b / mx;
        end
        exp_q.push_back('{i, r[i], g[i], b[i]});
      end
    end
    if (m[1]) begin
      for (int i = 0; i < NP; i++) begin
        y = clip(16 + fdiv256(66 * r[i] + 129 * g[i] + 25 * b[i] + 128));
        u = clip(128 + fdiv256(-38 * r[i] - 74 * g[i] + 112 * b[i] + 128));
        v = clip(128 + fdiv256(112 * r[i] - 94 * g[i] - 18 * b[i] + 128));
        r[i] = y; g[i] = u; b[i] = v;
        exp_q.push_back('{i, y, u, v});
      end
    end
    if (m[2]) begin
      for (int i = 0; i < NP; i++) begin
        k = (g[i] > cbl && g[i] < cbh && b[i] > crl && b[i] < crh) ? 255 : 0;
        if (k != 0 && skin < 31) skin++;
        exp_q.push_back('{i, k, k, k});
      end
    end
  endtask

  task automatic run(input logic [2:0] m, input int cbl, cbh, crl, crh, output int cycles);
    int skin_exp;
    expect_run(m, cbl, cbh, crl, crh, skin_exp);
    @(negedge clk);
    mode  = m;
    cb_lo = DW'(cbl); cb_hi = DW'(cbh);
    cr_lo = DW'(crl); cr_hi = DW'(crh);
    start = 1'b1;
    @(negedge clk);
    cycles = 1;
    check("busy_after_start", 32'(busy), 32'd1);
    while (done !== 1'b1 && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
    if (m[2]) check("skin_count", 32'(skin_count), skin_exp);
    @(negedge clk);
    check("done_hold", 32'(done), 32'd1);
    check("no_restart", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("done_clear", 32'(done), 32'd0);
    exp_q.delete();
  endtask

  task automatic fill_const(input int r, g, b);
    for (int i = 0; i < NP; i++) begin
      mr[i] = r; mg[i] = g; mb[i] = b;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NP; i++) begin
      mr[i] = $urandom_range(0, 255);
      mg[i] = $urandom_range(0, 255);
      mb[i] = $urandom_range(0, 255);
    end
  endtask

  function automatic int px(input int i);
    return (mr[i] << 16) | (mg[i] << 8) | mb[i];
  endfunction

  initial begin
    logic [2:0] rmodes [4] = '{3'b111, 3'b110, 3'b011, 3'b101};
    int skin_dummy;

    repeat (3) @(negedge clk);
    check("rst_we", 32'(bram.we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_skin", 32'(skin_count), 32'd0);
    check("rst_addr_rd", 32'(bram.addr_read), 32'd0);
    check("rst_addr_wr", 32'(bram.addr_write), 32'd0);
    check("rst_rgb_out", {8'h0, bram.r_out, bram.g_out, bram.b_out}, 32'd0);
    rst = 1'b1;

    fill_const(100, 100, 100);
    run(3'b001, 0, 0, 0, 0, cyc);
    check("latency_001", 32'(cyc >= 38 && cyc <= 40), 32'd1);
    check("uniform_px5", px(5), 32'h646464);

    fill_const(200, 100, 50);
    run(3'b001, 0, 0, 0, 0, cyc);
    check("comp_px0", px(0), 32'hC8320C);
    check("comp_px15", px(15), 32'hC8320C);

    fill_const(0, 0, 0);
    run(3'b001, 0, 0, 0, 0, cyc);
    check("zero_px15", px(15), 32'h000000);

    fill_rand();
    mr[0] = 0;   mg[0] = 0; mb[0] = 0;
    mr[1] = 255; mg[1] = 0; mb[1] = 0;
    run(3'b010, 0, 0, 0, 0, cyc);
    check("ycc_black", px(0), 32'h108080);
    check("ycc_red", px(1), 32'h525AF0);

    for (int i = 0; i < NP; i++) begin
      mr[i] = i * 10;
      case (i)
        0, 1, 2, 3, 4: begin mg[i] = 110; mb[i] = 150; end
        5:       begin mg[i] = 95;  mb[i] = 150; end
        6:       begin mg[i] = 120; mb[i] = 150; end
        7:       begin mg[i] = 110; mb[i] = 140; end
        8:       begin mg[i] = 110; mb[i] = 170; end
        default: begin mg[i] = 200; mb[i] = 30;  end
      endcase
    end
    run(3'b100, 95, 120, 140, 170, cyc);
    check("seg_skin_total", 32'(skin_count), 32'd5);
    check("seg_px0", px(0), 32'hFFFFFF);
    check("seg_px5_edge", px(5), 32'h000000);

    foreach (rmodes[j]) begin
      fill_rand();
      run(rmodes[j], 90, 150, 100, 170, cyc);
    end

    fill_rand();
    run(3'b000, 0, 0, 0, 0, cyc);
    check("latency_000", 32'(cyc <= 3), 32'd1);

    // Abort a run in the middle of compensation, then run a clean frame.
    fill_const(50, 60, 70);
    expect_run(3'b001, 0, 0, 0, 0, skin_dummy);
    @(negedge clk);
    mode  = 3'b001;
    start = 1'b1;
    wait_n = 0;
    while (bram.we !== 1'b1 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    check("comp_started", 32'(bram.we), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_we", 32'(bram.we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    start = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;

    fill_const(77, 150, 30);
    run(3'b001, 0, 0, 0, 0, cyc);
    check("rerun_latency", 32'(cyc >= 38 && cyc <= 40), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
